// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the sequence-detector logging path.
package seq_det_pkg;

  localparam int IDX_W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/match_idx_fifo.sv
// First-word-fall-through FIFO holding bit indices of detected matches.
// A push on a full FIFO is accepted only when a pop frees the head on the same edge.
module match_idx_fifo
  import seq_det_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      push_i,
  input  logic [W-1:0]              push_data_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic [W-1:0]              head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // When full, the write slot equals the head slot being popped this edge.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/seq_match_logger.sv
// Logs the stream bit index of each detector match into a FWFT FIFO,
// with a saturating match total and a sticky overflow flag.
module seq_match_logger
  import seq_det_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     bit_vld,
  input  logic                     match,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [IDX_W-1:0]         rd_data,
  output logic [cnt_w(DEPTH)-1:0]  fifo_cnt,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     ovf
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             ovf_q, ovf_d;
  logic             evt;
  logic             pop;
  logic             full;
  logic             empty;

  assign evt    = match && bit_vld;
  assign rd_vld = !empty;
  assign pop    = rd_vld && rd_rdy;

  match_idx_fifo #(
    .DEPTH (DEPTH),
    .W     (IDX_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .push_i      (evt),
    .push_data_i (idx_q),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (fifo_cnt),
    .head_o      (rd_data)
  );

  always_comb begin
    idx_d       = idx_q;
    match_cnt_d = match_cnt_q;
    ovf_d       = ovf_q;
    if (bit_vld) idx_d = idx_q + 1'b1;
    if (evt && (match_cnt_q != '1)) match_cnt_d = match_cnt_q + 1'b1;
    // Dropped only when full and the reader does not free a slot this edge.
    if (evt && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      match_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else if (clr) begin
      idx_q       <= '0;
      match_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      match_cnt_q <= match_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign match_cnt = match_cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed bench for seq_match_logger: default instance plus a CNT_W=4 instance
// sharing the same stimulus (the latter for match_cnt saturation).
module tb_seq_match_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       bit_vld;
  logic       match;
  logic       rd_rdy;

  logic       rd_vld;
  logic [7:0] rd_data;
  logic [2:0] fifo_cnt;
  logic [7:0] match_cnt;
  logic       ovf;

  logic       rd_vld_s;
  logic [7:0] rd_data_s;
  logic [2:0] fifo_cnt_s;
  logic [3:0] match_cnt_s;
  logic       ovf_s;

  int passed = 0;
  int total  = 0;
  int cur_idx = 0;

  always #5 clk = ~clk;

  seq_match_logger dut (
    .clk(clk), .rst(rst), .clr(clr), .bit_vld(bit_vld), .match(match), .rd_rdy(rd_rdy),
    .rd_vld(rd_vld), .rd_data(rd_data), .fifo_cnt(fifo_cnt), .match_cnt(match_cnt), .ovf(ovf)
  );

  seq_match_logger #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .bit_vld(bit_vld), .match(match), .rd_rdy(rd_rdy),
    .rd_vld(rd_vld_s), .rd_data(rd_data_s), .fifo_cnt(fifo_cnt_s), .match_cnt(match_cnt_s),
    .ovf(ovf_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    bit_vld = 1'b1;
    match   = 1'b0;
    repeat (n) tick();
    bit_vld = 1'b0;
    cur_idx += n;
  endtask

  task automatic match_bit();
    bit_vld = 1'b1;
    match   = 1'b1;
    tick();
    bit_vld = 1'b0;
    match   = 1'b0;
    cur_idx++;
  endtask

  task automatic push_at(input int target);
    advance(target - cur_idx);
    match_bit();
  endtask

  task automatic pop1();
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cur_idx = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_vld"},    rd_vld,    0);
    chk({tag, "_rd_data"},   rd_data,   0);
    chk({tag, "_fifo_cnt"},  fifo_cnt,  0);
    chk({tag, "_match_cnt"}, match_cnt, 0);
    chk({tag, "_ovf"},       ovf,       0);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; bit_vld = 1'b0; match = 1'b0; rd_rdy = 1'b0;
    #3;
    chk_all_zero("reset");
    #5 rst = 1'b1;
    tick();

    // Ordering: stream 1,0,1,1,0,1,1,0 with matches on bits 4 and 7
    for (int i = 0; i < 8; i++) begin
      bit_vld = 1'b1;
      match   = (i == 4 || i == 7);
      tick();
    end
    bit_vld = 1'b0; match = 1'b0; cur_idx = 8;
    chk("ord_cnt",  fifo_cnt, 2);
    chk("ord_vld",  rd_vld,   1);
    chk("ord_head", rd_data,  4);
    chk("ord_mcnt", match_cnt, 2);
    pop1();
    chk("ord_head2", rd_data,  7);
    chk("ord_cnt2",  fifo_cnt, 1);
    pop1();
    chk("ord_empty", rd_vld, 0);

    // match without bit_vld is ignored
    match = 1'b1;
    tick();
    match = 1'b0;
    chk("qual_cnt",  fifo_cnt,  0);
    chk("qual_mcnt", match_cnt, 2);

    // Overflow
    do_clr();
    push_at(10); push_at(20); push_at(30); push_at(40);
    chk("ovf_full_cnt", fifo_cnt, 4);
    chk("ovf_not_yet",  ovf,      0);
    push_at(50);
    chk("ovf_cnt",  fifo_cnt,  4);
    chk("ovf_set",  ovf,       1);
    chk("ovf_mcnt", match_cnt, 5);
    chk("ovf_d0", rd_data, 10); pop1();
    chk("ovf_d1", rd_data, 20); pop1();
    chk("ovf_d2", rd_data, 30); pop1();
    chk("ovf_d3", rd_data, 40); pop1();
    chk("ovf_drained", rd_vld, 0);
    chk("ovf_sticky",  ovf,    1);
    do_clr();
    chk("ovf_cleared", ovf, 0);

    // Full with simultaneous push and pop
    push_at(10); push_at(20); push_at(30); push_at(40);
    advance(60 - cur_idx);
    rd_rdy = 1'b1;
    match_bit();
    rd_rdy = 1'b0;
    chk("pp_cnt",  fifo_cnt, 4);
    chk("pp_ovf",  ovf,      0);
    chk("pp_mcnt", match_cnt, 5);
    chk("pp_d0", rd_data, 20); pop1();
    chk("pp_d1", rd_data, 30); pop1();
    chk("pp_d2", rd_data, 40); pop1();
    chk("pp_d3", rd_data, 60); pop1();
    chk("pp_empty", rd_vld, 0);

    // Reset mid-operation
    do_clr();
    push_at(1); push_at(2); push_at(3);
    chk("rm_cnt",  fifo_cnt,  3);
    chk("rm_mcnt", match_cnt, 3);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("rm");
    #1 rst = 1'b1;
    cur_idx = 0;
    tick();
    match_bit();
    chk("rm_idx0", rd_data,  0);
    chk("rm_vld",  rd_vld,   1);
    chk("rm_cnt1", fifo_cnt, 1);

    // Index wrap
    do_clr();
    advance(255);
    match_bit();
    match_bit();
    chk("wrap_cnt", fifo_cnt, 2);
    chk("wrap_255", rd_data, 255);
    pop1();
    chk("wrap_0", rd_data, 0);
    pop1();

    // Saturation with reader always ready
    do_clr();
    rd_rdy = 1'b1;
    repeat (20) match_bit();
    chk("sat_mcnt_s", match_cnt_s, 15);
    chk("sat_mcnt",   match_cnt,   20);
    chk("sat_ovf",    ovf,         0);
    clr = 1'b1; bit_vld = 1'b1; match = 1'b1;
    tick();
    clr = 1'b0; bit_vld = 1'b0; match = 1'b0; rd_rdy = 1'b0;
    chk_all_zero("clr_match");
    chk("clr_match_mcnt_s", match_cnt_s, 0);
    chk("clr_match_cnt_s",  fifo_cnt_s,  0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
